uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles allowed mid-frame before abort.
REQ-003 SHALL have parameter MAX_LEN, default 64, maximum payload bytes per frame.
REQ-004 SHALL have clk  input  1  the single clock; all logic samples on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have req_data  input  NUM_REQ*8  payload bytes; requester i uses bits [8i+7:8i].
REQ-007 SHALL have req_valid  input  NUM_REQ  per-requester byte valid.
REQ-008 SHALL have req_last  input  NUM_REQ  per-requester last-byte-of-frame flag, qualified by req_valid.
REQ-009 SHALL have req_ready  output  NUM_REQ  per-requester byte accept.
REQ-010 SHALL have tx_data  output  8  byte to the UART core transmit byte port.
REQ-011 SHALL have tx_valid  output  1  tx_data valid.
REQ-012 SHALL have tx_ready  input  1  UART core ready; a byte transfers on any edge with tx_valid && tx_ready.

Function
REQ-013 SHALL hold tx_data/tx_valid in an output register that is "free" when !tx_valid || tx_ready, and SHALL keep tx_data stable while tx_valid && !tx_ready.
REQ-014 SHALL implement states IDLE, HDR, DATA, ABORT.
REQ-015 IDLE: when the output register is free and any req_valid is high, SHALL grant the first valid requester at or after rr_ptr (wrapping), load tx_data = 8'hA0 | grant index, set tx_valid, enter HDR.
REQ-016 IDLE with register free and no req_valid: SHALL clear tx_valid.
REQ-017 HDR: on a header handshake, SHALL clear tx_valid and enter DATA; req_ready SHALL be 0 in HDR.
REQ-018 DATA: req_ready[g] = register free; req_ready of non-granted requesters SHALL be 0.
REQ-019 A byte accepted at edge N (req_valid[g] && req_ready[g]) SHALL appear on tx_data with tx_valid from cycle N+1; register free and no byte accepted SHALL clear tx_valid.
REQ-020 SHALL count accepted payload bytes with a counter wide enough for MAX_LEN; cleared on entering HDR.
REQ-021 Frame end SHALL occur on an accepted byte with req_last high or on the MAX_LEN-th accepted byte; SHALL then set rr_ptr = (g+1) mod NUM_REQ and enter IDLE.
REQ-022 SHALL count DATA cycles with register free and req_valid[g] low; counter cleared on any accepted byte and on entering DATA.
REQ-023 Counter reaching TIMEOUT SHALL enter ABORT, and SHALL set rr_ptr = (g+1) mod NUM_REQ.
REQ-024 ABORT: when the register is free, SHALL load tx_data = 8'hFF with tx_valid and enter IDLE; req_ready SHALL be 0.
REQ-025 Payload bytes SHALL pass unmodified; there is no escaping of 8'hA0..8'hA7 or 8'hFF.
REQ-026 Changes to req_valid of non-granted requesters mid-frame SHALL have no effect until IDLE.
REQ-027 After an abort, further bytes from the same requester SHALL be arbitrated as a new frame.

Reset
REQ-028 On rst_n low SHALL asynchronously force state IDLE, tx_valid 0, tx_data 8'h00, req_ready all 0, rr_ptr 0, and both counters 0.
REQ-029 Reset mid-frame SHALL discard the frame with no abort byte emitted.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the state enum, HDR_BASE = 8'hA0 and ABORT_BYTE = 8'hFF.
REQ-031 Round-robin selection SHALL be a combinational sub-module uart_rr_pick with inputs valid vector and rr_ptr, and outputs grant index and any-valid.

Verification
REQ-032 The bench SHALL cover: req 1 sends 8'h11, 8'h22 (last), tx_ready always 1 -> tx sequence A1, 11, 22; rr_ptr = 2.
REQ-033 The bench SHALL cover: reqs 0 and 2 each valid with a 1-byte frame (8'h55 last), rr_ptr = 0 -> A0, 55, A2, 55.
REQ-034 The bench SHALL cover: tx_ready low 5 cycles during header -> tx_data held at A3 throughout, req_ready all 0.
REQ-035 The bench SHALL cover: TIMEOUT = 8, req 0 sends one byte 8'h01 then drops valid -> A0, 01, FF; next frame from req 1 granted first.
REQ-036 The bench SHALL cover: MAX_LEN = 4, req 2 sends 6 bytes with no last -> A2, b0..b3, then A2 (or another valid requester's header per rr_ptr = 3), b4, b5.
REQ-037 The bench SHALL cover: rst_n low mid-DATA -> tx_valid 0 immediately; after release, state IDLE and rr_ptr 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared states and framing constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_ABORT
  } arb_state_t;

  localparam logic [7:0] HDR_BASE   = 8'hA0;
  localparam logic [7:0] ABORT_BYTE = 8'hFF;

  // Header byte announcing which requester owns the following frame
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    return HDR_BASE | {5'b0_0000, idx};
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin pick of the first valid requester at or after a pointer
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PW-1:0]      i_rr_ptr,
  output logic [PW-1:0]      o_grant,
  output logic               o_any
);

  // Scan from the farthest candidate down so the one nearest the pointer wins last
  always_comb begin : p_pick
    int            idx;
    logic [PW-1:0] sel;
    idx     = 0;
    sel     = '0;
    o_grant = '0;
    o_any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(i_rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = PW'(idx);
      if (i_valid[sel]) begin
        o_grant = sel;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin framing arbiter feeding bytes from several requesters into one UART transmitter
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int MAX_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  arb_state_t    r_state, w_state_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic          r_tx_valid, w_tx_valid_nxt;
  logic [PW-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [BW-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [IW-1:0] r_idle_cnt, w_idle_cnt_nxt;

  logic          w_free;
  logic          w_accept;
  logic          w_any;
  logic [PW-1:0] w_pick;
  logic [PW-1:0] w_next_ptr;
  logic [7:0]    w_bytes [NUM_REQ];
  logic [7:0]    w_byte;
  logic          w_last;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .i_valid  (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_pick),
    .o_any    (w_any)
  );

  // Split the packed payload bus into per-requester bytes
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_bytes[i] = req_data[i*8 +: 8];
    end
  end

  assign w_free     = !r_tx_valid || tx_ready;
  assign w_byte     = w_bytes[r_grant];
  assign w_last     = req_last[r_grant];
  assign w_accept   = (r_state == ST_DATA) && w_free && req_valid[r_grant];
  assign w_next_ptr = (r_grant == PW'(NUM_REQ - 1)) ? '0 : r_grant + PW'(1);
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;

  // Only the granted requester may push, and only while the output register can take a byte
  always_comb begin
    req_ready = '0;
    if ((r_state == ST_DATA) && w_free) begin
      req_ready[r_grant] = 1'b1;
    end
  end

  // Frame sequencing: header, payload until last/length limit, or abort on a stalled requester
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_free) begin
          if (w_any) begin
            w_grant_nxt    = w_pick;
            w_tx_data_nxt  = hdr_byte(3'(w_pick));
            w_tx_valid_nxt = 1'b1;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = ST_HDR;
          end else begin
            w_tx_valid_nxt = 1'b0;
          end
        end
      end
      ST_HDR: begin
        if (r_tx_valid && tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_idle_cnt_nxt = '0;
          w_state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_tx_data_nxt  = w_byte;
          w_tx_valid_nxt = 1'b1;
          w_idle_cnt_nxt = '0;
          w_byte_cnt_nxt = r_byte_cnt + BW'(1);
          if (w_last || (r_byte_cnt == BW'(MAX_LEN - 1))) begin
            w_rr_ptr_nxt = w_next_ptr;
            w_state_nxt  = ST_IDLE;
          end
        end else if (w_free) begin
          w_tx_valid_nxt = 1'b0;
          w_idle_cnt_nxt = r_idle_cnt + IW'(1);
          if (r_idle_cnt == IW'(TIMEOUT - 1)) begin
            w_rr_ptr_nxt = w_next_ptr;
            w_state_nxt  = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        if (w_free) begin
          w_tx_data_nxt  = ABORT_BYTE;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output register; reset drops any frame in flight without an abort byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for the UART transmit arbiter
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;
  localparam int MAX_LEN = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [8:0] src_q [NUM_REQ][$];

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    #2;
  endtask

  // Requester model: present the head of each source queue, retire it once accepted
  initial begin : driver
    logic [NUM_REQ-1:0] acc;
    logic [8:0]         head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (acc[r] && src_q[r].size() != 0) begin
          void'(src_q[r].pop_front());
        end
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if (src_q[r].size() != 0) begin
          head              = src_q[r][0];
          req_valid[r]      = 1'b1;
          req_data[8*r +: 8] = head[7:0];
          req_last[r]       = head[8];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
    end
  end

  // Transmit-side monitor: every completed handshake must match the scoreboard head
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_tx: observed %0h expected no byte", tx_data);
        end
        if (exp_q.size() != 0) begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    step(3);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_req_ready", req_ready, 4'h0);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    step(1);

    // Two simultaneous one-byte frames from pointer 0
    push_byte(0, 8'h55, 1'b1);
    push_byte(2, 8'h55, 1'b1);
    expect_byte(8'hA0); expect_byte(8'h55);
    expect_byte(8'hA2); expect_byte(8'h55);
    wait_drain(60, "drain_pair");

    // Single two-byte frame from requester 1 (pointer wraps from 3)
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b1);
    expect_byte(8'hA1); expect_byte(8'h11); expect_byte(8'h22);
    wait_drain(60, "drain_req1");

    // Header stalled by tx_ready; pointer 2 must pick requester 3 ahead of 1
    tx_ready = 1'b0;
    push_byte(3, 8'h33, 1'b1);
    push_byte(1, 8'h44, 1'b1);
    expect_byte(8'hA3); expect_byte(8'h33);
    expect_byte(8'hA1); expect_byte(8'h44);
    n = 0;
    @(negedge clk);
    while (tx_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hdr_hold_valid", tx_valid, 1'b1);
      check("hdr_hold_data", tx_data, 8'hA3);
      check("hdr_hold_ready", req_ready, 4'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    tx_ready = 1'b1;
    wait_drain(60, "drain_stall");

    // Requester 0 stops mid-frame: abort byte, then requester 1 wins next
    push_byte(0, 8'h01, 1'b0);
    expect_byte(8'hA0); expect_byte(8'h01); expect_byte(8'hFF);
    wait_drain(80, "drain_abort");
    push_byte(0, 8'h0A, 1'b1);
    push_byte(1, 8'h1B, 1'b1);
    expect_byte(8'hA1); expect_byte(8'h1B);
    expect_byte(8'hA0); expect_byte(8'h0A);
    wait_drain(60, "drain_after_abort");

    // Six bytes without last: split at MAX_LEN, remainder stalls into an abort
    for (int i = 0; i < 6; i++) begin
      push_byte(2, 8'h60 + 8'(i), 1'b0);
    end
    expect_byte(8'hA2);
    for (int i = 0; i < 4; i++) expect_byte(8'h60 + 8'(i));
    expect_byte(8'hA2); expect_byte(8'h64); expect_byte(8'h65);
    expect_byte(8'hFF);
    wait_drain(150, "drain_maxlen");

    // Reset in the middle of a payload
    push_byte(1, 8'h71, 1'b0);
    push_byte(1, 8'h72, 1'b0);
    push_byte(1, 8'h73, 1'b0);
    expect_byte(8'hA1); expect_byte(8'h71);
    wait_drain(60, "drain_pre_reset");
    tx_ready = 1'b0;
    step(2);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_req_ready", req_ready, 4'h0);
    for (int r = 0; r < NUM_REQ; r++) src_q[r].delete();
    exp_q.delete();
    step(3);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    step(1);

    // Pointer back at 0 after reset; payload values matching header/abort codes pass untouched
    push_byte(3, 8'hA5, 1'b1);
    push_byte(0, 8'hFF, 1'b1);
    expect_byte(8'hA0); expect_byte(8'hFF);
    expect_byte(8'hA3); expect_byte(8'hA5);
    wait_drain(60, "drain_post_reset");

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
